// File: rtl/ble_packet_receiver.sv
// ble_packet_receiver
// Rebuilds a fixed-length packet from UART byte strobes, sent least-significant
// byte first. The finished packet is held under a valid/ack handshake.
// Inter-byte timeout and overrun-while-held are reported as one-clock pulses.
module ble_packet_receiver #(
  parameter int PACKET_BYTES = 18,
  parameter int TIMEOUT      = 4000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      soft_reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  input  logic                      packet_ack,
  output logic [PACKET_BYTES*8-1:0] packet_data,
  output logic                      packet_valid,
  output logic [7:0]                byte_count,
  output logic                      busy,
  output logic                      timeout_error,
  output logic                      overrun_error
);

  localparam int DW = PACKET_BYTES * 8;
  // Timer width covers 0..TIMEOUT; it saturates instead of wrapping.
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};
  localparam logic [7:0]    LAST_IDX   = 8'(PACKET_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   packet_data_q, packet_data_d;
  logic [7:0]      byte_count_q, byte_count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            timeout_error_q, timeout_error_d;
  logic            overrun_error_q, overrun_error_d;

  // One-hot select of the byte lane addressed by the current byte count.
  logic [PACKET_BYTES-1:0] byte_sel;
  logic [DW-1:0]           data_with_byte;
  logic [DW-1:0]           data_first_byte;

  generate
    for (genvar gi = 0; gi < PACKET_BYTES; gi++) begin : g_byte_sel
      assign byte_sel[gi] = (byte_count_q == 8'(gi));
    end
  endgenerate

  // A fresh packet starts from all-zero data with the new byte in lane 0.
  assign data_first_byte = {{(DW - 8){1'b0}}, rx_data};

  // Current packet data with rx_data merged into the selected lane.
  always_comb begin
    data_with_byte = packet_data_q;
    for (int i = 0; i < PACKET_BYTES; i++) begin
      if (byte_sel[i]) begin
        data_with_byte[8*i +: 8] = rx_data;
      end
    end
  end

  // Next-state logic for the collect/hold state machine, timer and error pulses.
  always_comb begin
    state_d         = state_q;
    packet_data_d   = packet_data_q;
    byte_count_d    = byte_count_q;
    timer_d         = timer_q;
    timeout_error_d = 1'b0;
    overrun_error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          packet_data_d = data_first_byte;
          byte_count_d  = 8'd1;
          timer_d       = '0;
          state_d       = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (rx_valid) begin
          packet_data_d = data_with_byte;
          byte_count_d  = byte_count_q + 8'd1;
          timer_d       = '0;
          if (byte_count_q == LAST_IDX) begin
            state_d = S_HOLD;
          end
        end else if (timer_q == TIMER_LAST) begin
          // Gap too long: drop the partial packet but leave its bytes visible
          // until the next packet's first byte clears them.
          timeout_error_d = 1'b1;
          byte_count_d    = 8'd0;
          timer_d         = '0;
          state_d         = S_IDLE;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_HOLD: begin
        if (packet_ack && rx_valid) begin
          // Ack releases the held packet and the same strobe opens the next one.
          packet_data_d = data_first_byte;
          byte_count_d  = 8'd1;
          timer_d       = '0;
          state_d       = S_COLLECT;
        end else if (packet_ack) begin
          byte_count_d = 8'd0;
          state_d      = S_IDLE;
        end else if (rx_valid) begin
          overrun_error_d = 1'b1;
        end
      end

      default: begin
        state_d      = S_IDLE;
        byte_count_d = 8'd0;
        timer_d      = '0;
      end
    endcase

    // Synchronous clear behaves like reset and never raises an error pulse.
    if (soft_reset) begin
      state_d         = S_IDLE;
      packet_data_d   = '0;
      byte_count_d    = 8'd0;
      timer_d         = '0;
      timeout_error_d = 1'b0;
      overrun_error_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      packet_data_q   <= '0;
      byte_count_q    <= 8'd0;
      timer_q         <= '0;
      timeout_error_q <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      packet_data_q   <= packet_data_d;
      byte_count_q    <= byte_count_d;
      timer_q         <= timer_d;
      timeout_error_q <= timeout_error_d;
      overrun_error_q <= overrun_error_d;
    end
  end

  assign packet_data   = packet_data_q;
  assign byte_count    = byte_count_q;
  assign packet_valid  = (state_q == S_HOLD);
  assign busy          = (state_q != S_IDLE);
  assign timeout_error = timeout_error_q;
  assign overrun_error = overrun_error_q;

endmodule
